// File: rtl/lgn_frame_streamer.sv
// Host-side frame transmitter for the logic-gate-network classifier: binarizes a
// pixel stream, packs 8 pixels per byte into the shift-in port, then returns the decoded result.
module lgn_frame_streamer #(
  parameter int PIXELS        = 784,
  parameter int THRESHOLD     = 128,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        pix_last,
  output logic [7:0]  lgn_ui_in,
  output logic        lgn_write_enable,
  input  logic [15:0] lgn_uo_out,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [3:0]  result_digit,
  output logic [7:0]  result_score,
  output logic [1:0]  result_err,
  output logic        busy
);
  localparam int NBYTES = PIXELS / 8;
  localparam int PW     = $clog2(PIXELS);
  localparam int BW     = $clog2(NBYTES + 1);
  localparam logic [8:0] THR = 9'(THRESHOLD);

  typedef enum logic [1:0] {LOAD, PAD, SETTLE, RESULT} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pix_cnt;
  logic [BW-1:0]   wr_cnt;
  logic [3:0]      settle_cnt;
  logic [7:0]      pack, pack_nxt, emit_byte;
  logic            frame_err, accept, pix_bit, at_end, emit, settle_done;
  logic [2:0]      bit_idx;
  logic [3:0]      seg_digit;
  logic            seg_bad;

  assign accept      = pix_valid && pix_ready;
  assign pix_bit     = {1'b0, pix_data} >= THR;
  assign bit_idx     = pix_cnt[2:0];
  assign at_end      = pix_cnt == PW'(PIXELS - 1);
  assign settle_done = settle_cnt == 4'(SETTLE_CYCLES);
  assign busy        = state != LOAD;

  // First pixel of a byte clears the pack register, so a short frame is zero-filled for free.
  always_comb begin
    pack_nxt = (bit_idx == 3'd0) ? 8'h00 : pack;
    pack_nxt[3'd7 - bit_idx] = pix_bit;
  end

  always_comb begin
    seg_digit = 4'hF;
    seg_bad   = 1'b0;
    case (lgn_uo_out[6:0])
      7'h3F: seg_digit = 4'd0;
      7'h06: seg_digit = 4'd1;
      7'h5B: seg_digit = 4'd2;
      7'h4F: seg_digit = 4'd3;
      7'h66: seg_digit = 4'd4;
      7'h6D: seg_digit = 4'd5;
      7'h7C: seg_digit = 4'd6;
      7'h07: seg_digit = 4'd7;
      7'h7F: seg_digit = 4'd8;
      7'h67: seg_digit = 4'd9;
      default: seg_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_byte = pack_nxt;
    case (state)
      LOAD: if (accept) begin
        emit = bit_idx == 3'd7;
        if (at_end)        state_nxt = SETTLE;
        else if (pix_last) state_nxt = PAD;
      end
      PAD: begin
        emit      = 1'b1;
        emit_byte = pack;
        if (wr_cnt == BW'(NBYTES - 1)) state_nxt = SETTLE;
      end
      SETTLE:  if (settle_done) state_nxt = RESULT;
      RESULT:  if (result_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= LOAD;
      pix_ready        <= 1'b0;
      lgn_ui_in        <= 8'h00;
      lgn_write_enable <= 1'b0;
      result_valid     <= 1'b0;
      result_digit     <= 4'h0;
      result_score     <= 8'h00;
      result_err       <= 2'b00;
      pix_cnt          <= '0;
      wr_cnt           <= '0;
      settle_cnt       <= '0;
      pack             <= 8'h00;
      frame_err        <= 1'b0;
    end else begin
      state            <= state_nxt;
      pix_ready        <= state_nxt == LOAD;
      lgn_write_enable <= emit;
      if (emit) begin
        lgn_ui_in <= emit_byte;
        wr_cnt    <= wr_cnt + 1'b1;
      end
      case (state)
        LOAD: if (accept) begin
          // A completed byte is already on its way out; leave PAD nothing stale to resend.
          pack    <= (bit_idx == 3'd7) ? 8'h00 : pack_nxt;
          pix_cnt <= at_end ? '0 : pix_cnt + 1'b1;
          if (at_end != pix_last) frame_err <= 1'b1;
        end
        PAD: pack <= 8'h00;
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_done) begin
            settle_cnt   <= '0;
            result_valid <= 1'b1;
            result_digit <= seg_digit;
            result_score <= lgn_uo_out[15:8];
            result_err   <= {seg_bad | ~lgn_uo_out[7], frame_err};
          end
        end
        RESULT: if (result_ready) begin
          result_valid <= 1'b0;
          result_err   <= 2'b00;
          frame_err    <= 1'b0;
          pix_cnt      <= '0;
          wr_cnt       <= '0;
          pack         <= 8'h00;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lgn_frame_streamer.sv
// Directed/randomized bench for lgn_frame_streamer against a frame-level reference model.
module tb_lgn_frame_streamer;
  localparam int PIXELS = 784;
  localparam int NB     = PIXELS / 8;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        pix_last = 1'b0;
  logic [7:0]  lgn_ui_in;
  logic        lgn_write_enable;
  logic [15:0] lgn_uo_out;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [3:0]  result_digit;
  logic [7:0]  result_score;
  logic [1:0]  result_err;
  logic        busy;

  logic [6:0]  cls_seg = 7'h3F;
  logic [7:0]  cls_score = 8'h00;
  // Classifier stand-in: bit 7 mirrors ~write_enable as the real network does.
  assign lgn_uo_out = {cls_score, ~lgn_write_enable, cls_seg};

  lgn_frame_streamer #(.PIXELS(PIXELS), .THRESHOLD(128), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .lgn_ui_in(lgn_ui_in),
    .lgn_write_enable(lgn_write_enable), .lgn_uo_out(lgn_uo_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_digit(result_digit), .result_score(result_score),
    .result_err(result_err), .busy(busy));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0, rdy_busy = 0, last_idx;
  logic [7:0] pix [PIXELS];
  logic [7:0] wq[$];
  int         wc[$];
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (lgn_write_enable) begin wq.push_back(lgn_ui_in); wc.push_back(cyc); end
    if (busy && pix_ready) rdy_busy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_digit(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (seg_tab[d] == s) return 4'(d);
    return 4'hF;
  endfunction

  // Presents pixels 0..n-1, honouring pix_ready; pixel last_idx carries pix_last.
  task automatic drive_frame(input int n, input bit gaps);
    int i = 0, guard = 0;
    while (i < n && guard < 20000) begin
      @(negedge clk); guard++;
      if (pix_ready && (!gaps || $urandom_range(0, 3) != 0)) begin
        pix_valid = 1'b1; pix_data = pix[i]; pix_last = (i == last_idx); i++;
      end else begin
        pix_valid = 1'b0; pix_last = 1'b0;
      end
    end
    @(negedge clk); pix_valid = 1'b0; pix_last = 1'b0;
    chk("drive_bound", guard < 20000, 1);
  endtask

  // mode 0: all 0xFF, 1: 200 every 8th else 50, 2: random with 128/127 probes
  task automatic run_frame(input int mode, input int lastp, input logic [6:0] seg,
                           input logic [7:0] score, input bit gaps, input bit hold);
    int nacc, guard, nbad, adj, k0, rv_cyc;
    logic [7:0] eb;
    logic [3:0] d0; logic [7:0] s0; logic [1:0] e0;
    int viol;
    result_ready = !hold;
    cls_seg = seg; cls_score = score; last_idx = lastp;
    for (int i = 0; i < PIXELS; i++)
      case (mode)
        0: pix[i] = 8'hFF;
        1: pix[i] = (i % 8 == 0) ? 8'd200 : 8'd50;
        default: pix[i] = 8'($urandom_range(0, 255));
      endcase
    if (mode == 2) begin pix[3] = 8'd128; pix[4] = 8'd127; end
    nacc = (lastp >= 0) ? lastp + 1 : PIXELS;
    wq.delete(); wc.delete();
    drive_frame(nacc, gaps);
    guard = 0;
    while (!result_valid && guard < 500) begin @(negedge clk); guard++; end
    chk("result_bound", guard < 500, 1);
    rv_cyc = cyc;
    chk("write_count", wq.size(), NB);
    nbad = 0;
    for (int b = 0; b < NB && b < wq.size(); b++) begin
      eb = 8'h00;
      for (int j = 0; j < 8; j++)
        if (b * 8 + j < nacc && pix[b * 8 + j] >= 8'd128) eb[7 - j] = 1'b1;
      if (wq[b] !== eb) nbad++;
    end
    chk("byte_mismatches", nbad, 0);
    if (wc.size() > 0) chk("settle_latency", rv_cyc - wc[wc.size() - 1], SETTLE + 1);
    if (mode == 0) begin
      adj = 0;
      for (int i = 1; i < wc.size(); i++) if (wc[i] - wc[i - 1] == 1) adj++;
      chk("we_one_cycle", adj, 0);
    end
    if (lastp >= 0 && lastp < PIXELS - 1 && wc.size() == NB) begin
      k0 = lastp / 8;
      chk("pad_back_to_back", wc[NB - 1] - wc[k0], NB - 1 - k0);
    end
    chk("digit", result_digit, ref_digit(seg));
    chk("score", result_score, score);
    chk("err", result_err, {ref_digit(seg) == 4'hF, lastp != PIXELS - 1});
    if (hold) begin
      d0 = result_digit; s0 = result_score; e0 = result_err; viol = 0;
      repeat (20) begin
        @(negedge clk);
        if (!result_valid || pix_ready || result_digit !== d0 || result_score !== s0 ||
            result_err !== e0) viol++;
      end
      chk("hold_stable", viol, 0);
      chk("hold_no_writes", wq.size(), NB);
      result_ready = 1'b1;
    end
    @(negedge clk);
    chk("handshake_rv", result_valid, 0);
    chk("handshake_ready", pix_ready, 1);
    result_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_we", lgn_write_enable, 0);
    chk("rst_ui", lgn_ui_in, 0);
    chk("rst_outputs", {result_valid, result_digit, result_score, result_err}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", pix_ready, 1);

    run_frame(0, PIXELS - 1, 7'h3F, 8'h11, 1'b0, 1'b0);
    run_frame(1, PIXELS - 1, 7'h67, 8'hA5, 1'b1, 1'b0);
    run_frame(2, 9, 7'h4F, 8'h3C, 1'b1, 1'b0);
    run_frame(2, PIXELS - 1, 7'h12, 8'h77, 1'b1, 1'b1);
    run_frame(2, -1, 7'h6D, 8'h01, 1'b0, 1'b0);
    run_frame(2, 7'($urandom_range(0, 100)) * 8 + 7, seg_tab[$urandom_range(0, 9)],
              8'($urandom_range(0, 255)), 1'b1, 1'b0);

    // Mid-frame reset: drop the partial frame, then a clean frame must still be exact.
    last_idx = -1;
    for (int i = 0; i < PIXELS; i++) pix[i] = 8'($urandom_range(0, 255));
    drive_frame(300, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_we", lgn_write_enable, 0);
    chk("midrst_ready", pix_ready, 0);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", pix_ready, 1);
    run_frame(2, PIXELS - 1, seg_tab[$urandom_range(0, 9)], 8'($urandom_range(0, 255)),
              1'b1, 1'b0);

    chk("ready_while_busy", rdy_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lgn_frame_streamer.md
Name: lgn_frame_streamer

Overview:
- Host-side transmitter for the logic-gate-network classifier.
- Accepts a 28x28 grayscale pixel stream with a valid/ready handshake and binarizes each pixel against a threshold.
- Packs 8 pixels per byte and drives the classifier's 8-bit shift-in port with a one-cycle write enable per byte.
- After the frame, waits for the network to settle, samples the classifier outputs, decodes the seven-segment digit back to an index, and returns digit and score over a result handshake.

Parameters:
- PIXELS, 784, pixels per frame; must be a multiple of 8.
- THRESHOLD, 128, a pixel binarizes to 1 when pix_data >= THRESHOLD.
- SETTLE_CYCLES, 2, idle cycles after the last byte write before sampling classifier outputs; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pix_data  in  8  grayscale pixel
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_last  in  1  marks the final pixel of a frame
- lgn_ui_in  out  8  packed byte to the classifier shift-in port
- lgn_write_enable  out  1  classifier shift enable
- lgn_uo_out  in  16  classifier outputs: [6:0] seven-segment code, [7] ~write_enable, [15:8] score
- result_valid  out  1  result available
- result_ready  in  1  result consumed when result_valid && result_ready
- result_digit  out  4  decoded digit 0..9; 0xF when invalid
- result_score  out  8  lgn_uo_out[15:8] captured at sample time
- result_err  out  2  bit0 frame-length error, bit1 segment-decode error
- busy  out  1  high in PAD, SETTLE and RESULT

Behaviour:
- Clock and reset
  - One clock domain. Reset is synchronous and active-high, and is allowed at any point including mid-frame.
  - Reset values: state LOAD; pix_ready 0 during the reset cycle and 1 from the first cycle after; lgn_ui_in 0x00; lgn_write_enable 0; result_valid 0; result_digit 0; result_score 0; result_err 0; all counters 0.
- States: LOAD, PAD, SETTLE, RESULT.
- LOAD
  - pix_ready = 1 continuously; no stall, because one byte is emitted at most every 8 accepted pixels.
  - Each accepted pixel shifts one bit into the pack register. The first pixel of a byte lands in bit 7 and the 8th pixel in bit 0.
  - On acceptance of the 8th bit, the next cycle drives lgn_ui_in = packed byte and lgn_write_enable = 1 for exactly one cycle. Otherwise lgn_write_enable = 0 and lgn_ui_in holds its last value.
  - Frame byte order: byte 0 holds pixels 0..7. The classifier shifts left, so byte 0 ends in the top bits after 98 writes.
  - Pixel counter runs 0..PIXELS-1.
    - Pixel PIXELS-1 accepted with pix_last = 1: emit the last byte, go to SETTLE.
    - Pixel PIXELS-1 accepted without pix_last: set err bit0, emit the last byte, go to SETTLE. Excess pixels belong to the next frame.
    - pix_last on pixel k < PIXELS-1: set err bit0. Go to PAD, zero-filling the partial byte.
- PAD
  - pix_ready = 0.
  - Emit the zero-filled partial byte, then 0x00 bytes, one write per cycle, until PIXELS/8 writes total. Then go to SETTLE.
- SETTLE
  - Entered the cycle after the final write.
  - Count SETTLE_CYCLES cycles with no writes, then sample lgn_uo_out.
  - Go to RESULT with result_valid = 1 the next cycle.
- Segment decode (code bits [6:0])
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7C->6, 0x07->7, 0x7F->8, 0x67->9.
  - Any other code gives digit 0xF and sets err bit1.
  - Also set err bit1 if lgn_uo_out[7] == 0 at sample time.
- RESULT
  - result_valid stays 1 and result_* are held stable until result_ready.
  - On handshake: result_valid -> 0, counters and errors clear, state -> LOAD, pix_ready = 1 the next cycle.
  - pix_ready = 0 while in RESULT.
- Total writes per frame are always exactly PIXELS/8 (98). A reset mid-frame drops the partial frame with no further writes; the classifier register is fully overwritten by the next frame.

Test Plan:
- 784 pixels of 0xFF, pix_last on pixel 783, result_ready = 1 -> exactly 98 writes of 0xFF, each one cycle wide; result_valid asserted SETTLE_CYCLES+1 cycles after the last write; result_err = 0.
- Pixel i = 200 for i%8==0, else 50 -> every written byte is 0x80; pixel value 128 binarizes to 1 and 127 to 0.
- pix_last on pixel 9 -> byte0 per stimulus, byte1 zero-padded (only its first 2 bits from input), then 96 writes of 0x00 on back-to-back cycles; pix_ready = 0 during PAD; err bit0 = 1.
- lgn_uo_out model returns 0x{A5}80|0x67 -> result_digit 9, score 0xA5; model returns segment code 0x12 -> digit 0xF, err bit1 = 1.
- Hold result_ready = 0 for 20 cycles -> result_valid and result_* stable, pix_ready = 0, no writes; release -> next frame accepted on the following cycle.
- Assert reset after 300 pixels -> next cycle lgn_write_enable = 0 and pix_ready = 0; then a full clean frame yields exactly 98 writes and a correct result.
